// File: rtl/buf_add_alloc.sv
// Free-buffer-address allocator: 16-entry free list, req/ack grant FSM,
// and per-address aging that reclaims buffers never released by their user.
module buf_add_alloc #(
  parameter int TICK_DIV = 1024,
  parameter int AGE_W    = 8,
  parameter int AGE_MAX  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_addr_wr,
  input  logic [3:0] buf_addr,
  input  logic       alloc_req,
  output logic       alloc_ack,
  output logic [3:0] alloc_addr,
  output logic       alloc_empty,
  output logic [4:0] free_count,
  input  logic       release_wr,
  input  logic [3:0] release_addr,
  output logic       aging_recycle_addr_wr,
  output logic [3:0] aging_recycle_addr,
  output logic [1:0] err_flags
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [AGE_W-1:0]  AGE_LIM   = AGE_W'(AGE_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        mem [16];
  logic [3:0]        rd_ptr, wr_ptr;
  logic [4:0]        count, count_nxt;
  logic [15:0]       in_use, in_use_nxt;
  logic [AGE_W-1:0]  age [16];
  logic [TICK_W-1:0] tick;
  logic [3:0]        scan_ptr;

  logic       push, pop, overflow;
  logic [3:0] grant_addr;
  logic       tick_wrap, scan_hit, expire, rel_ok, rel_err;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a >= AGE_LIM) ? AGE_LIM : a + AGE_W'(1);
  endfunction

  assign free_count = count;
  assign grant_addr = mem[rd_ptr];
  assign push       = buf_addr_wr && (count != 5'd16);
  assign overflow   = buf_addr_wr && (count == 5'd16);
  assign count_nxt  = count + {4'b0, push} - {4'b0, pop};
  assign tick_wrap  = (tick == TICK_LAST);
  assign rel_ok     = release_wr && in_use[release_addr];
  assign rel_err    = release_wr && !in_use[release_addr];
  assign scan_hit   = in_use[scan_ptr] && (age[scan_ptr] >= AGE_LIM);

  // A release or a fresh grant on the scanned address overrides expiry.
  assign expire = scan_hit
                  && !(release_wr && (release_addr == scan_ptr))
                  && !(pop && (grant_addr == scan_ptr));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (alloc_req && (count != 5'd0)) begin
          state_nxt = GRANT;
          pop       = 1'b1;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_use_nxt = in_use;
    if (rel_ok) in_use_nxt[release_addr] = 1'b0;
    if (expire) in_use_nxt[scan_ptr]     = 1'b0;
    if (pop)    in_use_nxt[grant_addr]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= buf_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      rd_ptr                <= 4'd0;
      wr_ptr                <= 4'd0;
      count                 <= 5'd0;
      in_use                <= 16'd0;
      tick                  <= '0;
      scan_ptr              <= 4'd0;
      alloc_ack             <= 1'b0;
      alloc_addr            <= 4'd0;
      alloc_empty           <= 1'b1;
      aging_recycle_addr_wr <= 1'b0;
      aging_recycle_addr    <= 4'd0;
      err_flags             <= 2'b00;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      alloc_empty <= (count_nxt == 5'd0);
      in_use      <= in_use_nxt;
      scan_ptr    <= scan_ptr + 4'd1;
      tick        <= tick_wrap ? '0 : tick + TICK_W'(1);
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      alloc_ack <= pop;
      if (pop) alloc_addr <= grant_addr;
      aging_recycle_addr_wr <= expire;
      if (expire) aging_recycle_addr <= scan_ptr;
      err_flags <= err_flags | {rel_err, overflow};
    end
  end

  // Ages restart on grant and climb once per tick while in use, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pop && (grant_addr == 4'(i)))
          age[i] <= '0;
        else if (tick_wrap && in_use[i])
          age[i] <= age_inc(age[i]);
      end
    end
  end

endmodule

// File: doc/buf_add_alloc.md
Name: buf_add_alloc

Overview:
- Consumer end of the free-buffer-address interface: receives free addresses (buf_addr_wr/buf_addr) from the buffer address manager into a 16-entry free list.
- Grants addresses to the packet-input path through a req/ack handshake.
- Tracks in-use buffers with per-address age counters. Buffers never released before timeout are reclaimed and emitted on aging_recycle_addr, closing the loop back to the manager.

Parameters:
- TICK_DIV, 1024: clk cycles per aging tick (≥2).
- AGE_W, 8: width of each per-address age counter.
- AGE_MAX, 200: age at which an in-use buffer expires (1..2^AGE_W-1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- buf_addr_wr  in  1  free address valid, 1-cycle pulse
- buf_addr  in  4  free address returned to pool
- alloc_req  in  1  level request for a buffer address
- alloc_ack  out  1  1-cycle grant pulse
- alloc_addr  out  4  granted address, valid when alloc_ack=1
- alloc_empty  out  1  free list empty
- free_count  out  5  free-list occupancy 0..16
- release_wr  in  1  buffer consumed normally, pulse
- release_addr  in  4  address being released
- aging_recycle_addr_wr  out  1  expired-address pulse
- aging_recycle_addr  out  4  expired address
- err_flags  out  2  sticky: [0] free-list overflow, [1] release of non-in-use address

Behaviour:
- Reset (async, reset=0):
  - All outputs 0, except alloc_empty=1.
  - Free list empty; in_use[15:0]=0; all ages 0; tick counter 0; scan pointer 0.
  - Reset mid-grant cancels the grant; addresses held in the free list are lost. The manager re-seeds all 16 after reset.
- Free list:
  - Circular FIFO, depth 16, 4-bit rd/wr pointers, 5-bit count.
  - buf_addr_wr with count=16: write dropped, err_flags[0] set.
  - No write-to-read bypass: a write into an empty list is grantable the next cycle.
  - Simultaneous push and pop: count unchanged.
- Allocation FSM, states IDLE and GRANT:
  - IDLE → GRANT when alloc_req=1 and count>0. The pop happens at this edge.
  - In GRANT (one cycle): alloc_ack=1, alloc_addr=popped entry, in_use[addr]←1, age[addr]←0. Next state is always IDLE.
  - Request-to-ack latency is 1 cycle. Maximum rate is one grant per 2 cycles.
  - alloc_req held high gives repeated grants while count>0. The requester drops alloc_req on the cycle it sees alloc_ack if it needs only one.
  - alloc_addr holds its last value when alloc_ack=0.
- Release:
  - release_wr with in_use[release_addr]=1: clears in_use. The address is NOT returned to the free list here; the output path recycles it via the manager.
  - release_wr with in_use[release_addr]=0: ignored, err_flags[1] set.
- Aging:
  - Tick counter counts 0..TICK_DIV-1 and wraps. On wrap, every in_use entry increments its age, saturating at AGE_MAX.
  - Scanner visits one address per cycle, pointer 0..15 wrapping.
  - If in_use[p]=1 and age[p]≥AGE_MAX: in_use[p]←0, and next cycle aging_recycle_addr_wr=1 with aging_recycle_addr=p. At most one expiry per cycle.
  - Expiry latency after reaching AGE_MAX is ≤16 cycles.
- Simultaneous events on the same address:
  - release_wr and expiry in the same cycle: release wins, no aging emit, no error.
  - Grant writing in_use/age and scanner visiting the same address: the grant's values take effect; no expiry that cycle.
- Outputs are registered. aging_recycle_addr holds its value between pulses.

Test Plan:
- Reset, then 16 buf_addr_wr pulses with addresses 0..15 → free_count=16, alloc_empty=0, err_flags=0.
- alloc_req held high for 40 cycles after seeding → 16 alloc_ack pulses on alternate cycles with alloc_addr 0,1,…,15; then alloc_empty=1 and no further ack.
- 17th buf_addr_wr while full (addr 5) → dropped, free_count stays 16, err_flags[0]=1.
- TICK_DIV=4, AGE_MAX=3: allocate addr 7, no release → aging_recycle_addr_wr pulses once with addr 7 within 12+16 cycles of the grant; in_use[7] cleared; a later release_wr of 7 sets err_flags[1].
- Same params: allocate addr 2, release_wr addr 2 after 5 cycles → no aging pulse ever, err_flags[1]=0.
- Force release_wr addr 3 in the exact cycle the scanner expires addr 3 → no aging pulse, in_use[3]=0; assert reset mid-GRANT → alloc_ack=0 immediately, free_count=0.
